led_snake_top: RTL and testbench

Serial driver for a chain of 8 WS281x-style RGB LEDs on a single data wire. It captures eight 24-bit colour words, sends a low reset/latch interval, then sends the 8×24 bits MSB-first using pulse-width encoding. After each set it requests new colour data and repeats. Debug ports expose the internal timers and the frame pointer for bench observation.

---
 rtl/led_snake_pkg.sv | 18 +
 rtl/led_pulse_timer.sv | 39 +++
 rtl/led_snake_top.sv | 151 +++++++++++++++
 tb/tb_led_snake_top.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/led_snake_pkg.sv
// Shared types and default timing for the WS281x LED snake driver.
package led_snake_pkg;

    typedef enum logic [1:0] {
        RST,
        HIGH,
        LOW
    } state_e;

    localparam int unsigned DEF_L_TIME   = 80;
    localparam int unsigned DEF_S_TIME   = 40;
    localparam int unsigned DEF_R_TIME   = 5000;
    localparam int unsigned DEF_CNT_W    = 16;

    localparam int unsigned NUM_LEDS     = 8;
    localparam int unsigned BITS_PER_LED = 24;

endpackage

// File: rtl/led_pulse_timer.sv
// Free-running phase timer: counts 0..LIMIT-1 while run is high, holds 0 otherwise.
module led_pulse_timer #(
    parameter int unsigned LIMIT = 80,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             measured
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrapping to 0 on the last count lets back-to-back phases on the same timer start clean.
    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy     = rstn & run;
    assign measured = busy & (cnt_q == LAST);
    assign cnt      = rstn ? cnt_q : '0;

endmodule

// File: rtl/led_snake_top.sv
// Serial WS281x driver for an 8-LED chain: latch interval, then 8x24 pulse-width bits MSB first.
module led_snake_top
    import led_snake_pkg::*;
#(
    parameter int unsigned L_TIME = DEF_L_TIME,
    parameter int unsigned S_TIME = DEF_S_TIME,
    parameter int unsigned R_TIME = DEF_R_TIME,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [23:0]      led0,
    input  logic [23:0]      led1,
    input  logic [23:0]      led2,
    input  logic [23:0]      led3,
    input  logic [23:0]      led4,
    input  logic [23:0]      led5,
    input  logic [23:0]      led6,
    input  logic [23:0]      led7,
    output logic             led_stripe_pin,
    output logic             new_frames_set_rqst,
    output logic [23:0]      frame_to_transmit_dbg,
    output logic [2:0]       no_of_frame_dbg,
    output logic             reset_finish_dbg,
    output logic             l_time_wait_dbg,
    output logic             l_time_measured_dbg,
    output logic             s_time_wait_dbg,
    output logic             s_time_measured_dbg,
    output logic [CNT_W-1:0] r_time_cnt_dbg,
    output logic [CNT_W-1:0] l_time_cnt_dbg,
    output logic [CNT_W-1:0] s_time_cnt_dbg
);

    localparam logic [4:0] LAST_BIT   = 5'(BITS_PER_LED - 1);
    localparam logic [2:0] LAST_FRAME = 3'(NUM_LEDS - 1);

    state_e state_q, state_d;
    logic [2:0] frame_q, frame_d;
    logic [4:0] bit_idx_q, bit_idx_d;
    logic [NUM_LEDS-1:0][BITS_PER_LED-1:0] led_buf_q, led_buf_d;
    logic rqst_q, rqst_d;

    logic cur_bit;
    logic r_run, l_run, s_run;
    logic r_meas, l_meas, s_meas;
    logic r_busy_unused, l_busy, s_busy;
    logic [CNT_W-1:0] r_cnt, l_cnt, s_cnt;

    assign cur_bit = led_buf_q[frame_q][bit_idx_q];

    // A 1 bit spends the long time high; a 0 bit spends it low.
    assign r_run = (state_q == RST);
    assign l_run = ((state_q == HIGH) && cur_bit) || ((state_q == LOW) && !cur_bit);
    assign s_run = ((state_q == HIGH) && !cur_bit) || ((state_q == LOW) && cur_bit);

    led_pulse_timer #(.LIMIT(R_TIME), .CNT_W(CNT_W)) u_r_timer (
        .clk      (clk),
        .rstn     (rstn),
        .run      (r_run),
        .cnt      (r_cnt),
        .busy     (r_busy_unused),
        .measured (r_meas)
    );

    led_pulse_timer #(.LIMIT(L_TIME), .CNT_W(CNT_W)) u_l_timer (
        .clk      (clk),
        .rstn     (rstn),
        .run      (l_run),
        .cnt      (l_cnt),
        .busy     (l_busy),
        .measured (l_meas)
    );

    led_pulse_timer #(.LIMIT(S_TIME), .CNT_W(CNT_W)) u_s_timer (
        .clk      (clk),
        .rstn     (rstn),
        .run      (s_run),
        .cnt      (s_cnt),
        .busy     (s_busy),
        .measured (s_meas)
    );

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        led_buf_d = led_buf_q;
        rqst_d    = 1'b0;
        case (state_q)
            RST: begin
                if (r_meas) begin
                    led_buf_d = {led7, led6, led5, led4, led3, led2, led1, led0};
                    frame_d   = '0;
                    bit_idx_d = LAST_BIT;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (l_meas || s_meas) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (l_meas || s_meas) begin
                    state_d = HIGH;
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - 5'd1;
                    end else if (frame_q != LAST_FRAME) begin
                        frame_d   = frame_q + 3'd1;
                        bit_idx_d = LAST_BIT;
                    end else begin
                        state_d = RST;
                        rqst_d  = 1'b1;
                    end
                end
            end
            default: state_d = RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= RST;
            frame_q   <= '0;
            bit_idx_q <= '0;
            led_buf_q <= '0;
            rqst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            led_buf_q <= led_buf_d;
            rqst_q    <= rqst_d;
        end
    end

    // Outputs are gated by rstn so an asserted reset silences the line in the same cycle.
    assign led_stripe_pin        = rstn && (state_q == HIGH);
    assign new_frames_set_rqst   = rstn && rqst_q;
    assign frame_to_transmit_dbg = rstn ? led_buf_q[frame_q] : '0;
    assign no_of_frame_dbg       = rstn ? frame_q : '0;
    assign reset_finish_dbg      = r_meas;
    assign l_time_wait_dbg       = l_busy;
    assign l_time_measured_dbg   = l_meas;
    assign s_time_wait_dbg       = s_busy;
    assign s_time_measured_dbg   = s_meas;
    assign r_time_cnt_dbg        = r_cnt;
    assign l_time_cnt_dbg        = l_cnt;
    assign s_time_cnt_dbg        = s_cnt;

endmodule

// File: tb/tb_led_snake_top.sv
// Cycle-level bench for led_snake_top against a waveform model derived from the bit-timing rules.
module tb_led_snake_top;

    localparam int R_T    = 5000;
    localparam int L_T    = 80;
    localparam int S_T    = 40;
    localparam int BIT_T  = L_T + S_T;
    localparam int FRM_T  = 24 * BIT_T;
    localparam int PERIOD = R_T + 8 * FRM_T;

    logic        clk = 1'b0;
    logic        rstn;
    logic [23:0] led_in [8];

    logic        pin, rqst, rf, lw, lm, sw, sm;
    logic [23:0] word;
    logic [2:0]  frame;
    logic [15:0] rc, lc, sc;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cur_it = 0;

    always #5 clk = ~clk;

    led_snake_top dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .led0                  (led_in[0]),
        .led1                  (led_in[1]),
        .led2                  (led_in[2]),
        .led3                  (led_in[3]),
        .led4                  (led_in[4]),
        .led5                  (led_in[5]),
        .led6                  (led_in[6]),
        .led7                  (led_in[7]),
        .led_stripe_pin        (pin),
        .new_frames_set_rqst   (rqst),
        .frame_to_transmit_dbg (word),
        .no_of_frame_dbg       (frame),
        .reset_finish_dbg      (rf),
        .l_time_wait_dbg       (lw),
        .l_time_measured_dbg   (lm),
        .s_time_wait_dbg       (sw),
        .s_time_measured_dbg   (sm),
        .r_time_cnt_dbg        (rc),
        .l_time_cnt_dbg        (lc),
        .s_time_cnt_dbg        (sc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cur_it);
        end
    endtask

    // Model state: cycle within the current set (0 = first latch-interval cycle)
    int          mt     = 0;
    int          mframe = 0;
    bit          mrqst  = 1'b0;
    int          set_no = 0;
    logic [23:0] mdata [8];
    bit          done   = 1'b0;

    initial begin
        logic        e_pin, e_rq, e_rf, e_lw, e_lm, e_sw, e_sm, b;
        int          e_rc, e_lc, e_sc, e_fr, p, bn, w, bp;
        logic [23:0] e_word, cur;

        rstn = 1'b0;
        led_in[0] = 24'h111111; led_in[1] = 24'hBBBBBB;
        led_in[2] = 24'h444444; led_in[3] = 24'h888888;
        led_in[4] = 24'h999999; led_in[5] = 24'hAAAAAA;
        led_in[6] = 24'hCCCCCC; led_in[7] = 24'h222222;
        for (int i = 0; i < 8; i++) mdata[i] = '0;

        for (int it = 0; it < 60000 && !done; it++) begin
            @(posedge clk);
            #1;
            cur_it = it;
            rstn = (it != 0);
            if (set_no == 0 && mt == R_T + FRM_T + 100) begin
                led_in[3] = 24'hFFFFFF;
            end
            if (set_no == 1 && mt == R_T + 4 * FRM_T + 1000) begin
                rstn = 1'b0;
                for (int i = 0; i < 8; i++) led_in[i] = 24'($urandom);
            end
            if (set_no == 2 && mt == R_T + FRM_T) begin
                done = 1'b1;
            end

            @(negedge clk);
            e_pin = 0; e_rq = 0; e_rf = 0; e_lw = 0; e_lm = 0; e_sw = 0; e_sm = 0;
            e_rc = 0; e_lc = 0; e_sc = 0; e_fr = 0; e_word = '0;
            if (rstn) begin
                e_rq = mrqst;
                if (mt < R_T) begin
                    e_rc = mt;
                    e_rf = (mt == R_T - 1);
                    e_fr = mframe;
                end else begin
                    p  = mt - R_T;
                    bn = p / BIT_T;
                    w  = p % BIT_T;
                    e_fr = bn / 24;
                    bp = 23 - (bn % 24);
                    cur = mdata[e_fr];
                    b = cur[bp];
                    e_pin = (w < (b ? L_T : S_T));
                    if (b) begin
                        if (w < L_T) begin e_lw = 1; e_lc = w; end
                        else begin e_sw = 1; e_sc = w - L_T; end
                    end else begin
                        if (w < S_T) begin e_sw = 1; e_sc = w; end
                        else begin e_lw = 1; e_lc = w - S_T; end
                    end
                    e_lm = e_lw && (e_lc == L_T - 1);
                    e_sm = e_sw && (e_sc == S_T - 1);
                    mframe = e_fr;
                end
                e_word = mdata[e_fr];
            end

            check_val("pin",      32'(pin),   32'(e_pin));
            check_val("rqst",     32'(rqst),  32'(e_rq));
            check_val("rst_fin",  32'(rf),    32'(e_rf));
            check_val("frame_no", 32'(frame), 32'(e_fr));
            check_val("word",     32'(word),  32'(e_word));
            check_val("l_wait",   32'(lw),    32'(e_lw));
            check_val("l_meas",   32'(lm),    32'(e_lm));
            check_val("s_wait",   32'(sw),    32'(e_sw));
            check_val("s_meas",   32'(sm),    32'(e_sm));
            check_val("r_cnt",    32'(rc),    32'(e_rc));
            check_val("l_cnt",    32'(lc),    32'(e_lc));
            check_val("s_cnt",    32'(sc),    32'(e_sc));

            if (!rstn) begin
                mt = 0;
                mrqst = 1'b0;
                mframe = 0;
                for (int i = 0; i < 8; i++) mdata[i] = '0;
                if (set_no == 1) set_no = 2;
            end else begin
                if (mt == R_T - 1) begin
                    for (int i = 0; i < 8; i++) mdata[i] = led_in[i];
                end
                if (mt == PERIOD - 1) begin
                    mt = 0;
                    mrqst = 1'b1;
                    set_no++;
                end else begin
                    mt++;
                    mrqst = 1'b0;
                end
            end
        end

        check_val("scenario_done", 32'(done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
